if_stage: RTL and testbench

- Instruction-fetch stage and phase sequencer for the 5-phase core (f, r, x, m, w).
- Generates the one-hot phase vector and fetches the instruction word from instruction memory over a req/ack handshake.
- Latches the fetched word into ir, which the register-address decoder consumes in phase r.
- Maintains the PC, applies branch redirects at the end of phase w, and counts retired instructions.

---
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage and 5-phase sequencer (f, r, x, m, w)
//
// Sequences the one-hot phase vector, fetches the instruction word over a
// req/ack handshake in phase f, latches it into ir, and advances or redirects
// the PC at the closing edge of phase w while counting retired instructions.
//
// Optional build macro: IF_TIMEOUT_EN
//   defined     : f gives up after TIMEOUT_CYC ack-less cycles, loads a NOP into
//                 ir and sets the sticky fetch_err flag.
//   not defined : f waits for ack indefinitely; fetch_err is tied to 0.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   phase[4:0]     out  one-hot phase (bit0=f .. bit4=w), 00000 = halted
//   ir[31:0]       out  latched instruction word
//   pc[31:0]       out  address of the current instruction
//   imem_req       out  fetch request (high throughout phase f)
//   imem_addr[31:0] out fetch address (= pc)
//   imem_rdata[31:0] in instruction data, valid with imem_ack
//   imem_ack       in   fetch complete
//   branch_taken   in   redirect request, sampled in phase w
//   branch_target[31:0] in redirect address, sampled in phase w
//   halt           in   stop request, sampled in phase w and while halted
//   instr_cnt[31:0] out retired-instruction count
//   fetch_err      out  sticky fetch-timeout flag

module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  phase,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] instr_cnt,
  output logic        fetch_err
);

  // The state encoding is the phase vector itself, so phase is registered.
  typedef enum logic [4:0] {
    PH_HALT = 5'b00000,
    PH_F    = 5'b00001,
    PH_R    = 5'b00010,
    PH_X    = 5'b00100,
    PH_M    = 5'b01000,
    PH_W    = 5'b10000
  } phase_t;

  phase_t state;

  assign phase     = state;
  assign imem_req  = (state == PH_F);
  assign imem_addr = pc;

  // Branch targets are word aligned; the low two target bits are dropped.
  logic unused_target_lsbs;
  assign unused_target_lsbs = &{1'b0, branch_target[1:0]};

  // A timeout of zero cycles has no meaning; such a configuration elaborates
  // to nothing distinguishable and is left to the integrator to avoid.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_invalid
  end

`ifdef IF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Counts completed ack-less f cycles; zero on every entry to f because it
  // is cleared in every other phase.
  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PH_F;
      pc        <= RESET_PC;
      ir        <= 32'h0000_0000;
      instr_cnt <= 32'h0000_0000;
`ifdef IF_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef IF_TIMEOUT_EN
      if (state != PH_F) begin
        wait_cnt <= '0;
      end
`endif
      case (state)
        PH_F: begin
          // An ack on the timeout edge wins: normal load, no error.
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= PH_R;
          end
`ifdef IF_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            ir    <= 32'h0000_0000;
            err_q <= 1'b1;
            state <= PH_R;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        PH_R: state <= PH_X;
        PH_X: state <= PH_M;
        PH_M: state <= PH_W;
        PH_W: begin
          pc        <= branch_taken ? {branch_target[31:2], 2'b00} : pc + 32'd4;
          instr_cnt <= instr_cnt + 32'd1;
          state     <= halt ? PH_HALT : PH_F;
        end
        PH_HALT: begin
          if (!halt) begin
            state <= PH_F;
          end
        end
        default: state <= PH_F;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage

module tb_if_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  phase;
  logic [31:0] ir, pc, imem_addr, imem_rdata, branch_target, instr_cnt;
  logic        imem_req, imem_ack, branch_taken, halt, fetch_err;

  if_stage #(.RESET_PC(RPC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .phase(phase), .ir(ir), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .instr_cnt(instr_cnt),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural model: next pc, retired count and current instruction.
  logic [31:0] mpc, mcnt, mir;

  // Runs one instruction. Entered and left just after a negedge in phase f.
  // dly = ack-less f cycles before the ack; hcyc = halted cycles if hlt.
  task automatic do_instr(input int dly, input logic [31:0] word, input bit br,
                          input logic [31:0] tgt, input bit hlt, input int hcyc);
    logic [4:0] exp_ph;
    for (int c = 0; c <= dly; c++) begin
      if (c > 0) @(negedge clk);
      checks += 3;
      if (phase !== 5'b00001) begin errors++; $display("FAIL f_phase got=%b exp=00001", phase); end
      if (imem_req !== 1'b1) begin errors++; $display("FAIL f_req got=%b exp=1", imem_req); end
      if (imem_addr !== mpc) begin errors++; $display("FAIL f_addr got=%h exp=%h", imem_addr, mpc); end
      branch_taken = 1'b0;
      halt         = 1'b0;
      imem_ack     = (c == dly);
      imem_rdata   = (c == dly) ? word : $urandom;
    end
    mir = word;
    for (int p = 1; p <= 4; p++) begin
      @(negedge clk);
      exp_ph = 5'b00001 << p;
      checks += 4;
      if (phase !== exp_ph) begin errors++; $display("FAIL seq_phase got=%b exp=%b", phase, exp_ph); end
      if (ir !== mir) begin errors++; $display("FAIL ir_hold got=%h exp=%h", ir, mir); end
      if (imem_req !== 1'b0) begin errors++; $display("FAIL req_low got=%b exp=0", imem_req); end
      if (instr_cnt !== mcnt) begin errors++; $display("FAIL cnt_hold got=%h exp=%h", instr_cnt, mcnt); end
      // Stray acks, branches and halts outside w must have no effect.
      imem_ack      = 1'($urandom_range(0, 1));
      imem_rdata    = $urandom;
      branch_taken  = 1'b1;
      branch_target = $urandom;
      halt          = 1'($urandom_range(0, 1));
      if (p == 4) begin
        checks++;
        if (pc !== mpc) begin errors++; $display("FAIL w_pc got=%h exp=%h", pc, mpc); end
        branch_taken  = br;
        branch_target = tgt;
        halt          = hlt;
      end
    end
    mpc  = br ? {tgt[31:2], 2'b00} : mpc + 32'd4;
    mcnt = mcnt + 32'd1;
    if (hlt) begin
      for (int h = 0; h < hcyc; h++) begin
        @(negedge clk);
        checks += 4;
        if (phase !== 5'b00000) begin errors++; $display("FAIL halt_phase got=%b exp=00000", phase); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got=%b exp=0", imem_req); end
        if (pc !== mpc) begin errors++; $display("FAIL halt_pc got=%h exp=%h", pc, mpc); end
        if (instr_cnt !== mcnt) begin errors++; $display("FAIL halt_cnt got=%h exp=%h", instr_cnt, mcnt); end
        imem_ack     = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        halt         = (h != hcyc - 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    imem_ack = 1'b0; imem_rdata = '0; branch_taken = 1'b0;
    branch_target = '0; halt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks += 6;
    if (phase !== 5'b00001) begin errors++; $display("FAIL rst_phase got=%b exp=00001", phase); end
    if (pc !== RPC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, RPC); end
    if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir got=%h exp=0", ir); end
    if (instr_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got=%h exp=0", instr_cnt); end
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got=%b exp=1", imem_req); end
    @(negedge clk);
    rst = 1'b0;
    mpc = RPC; mcnt = '0; mir = '0;
  endtask

  task automatic test_basic;
    do_instr(0, 32'h2A1B_0000, 1'b0, '0, 1'b0, 1);
    checks += 2;
    if (pc !== 32'h4) begin errors++; $display("FAIL basic_pc got=%h exp=4", pc); end
    if (instr_cnt !== 32'h1) begin errors++; $display("FAIL basic_cnt got=%h exp=1", instr_cnt); end
  endtask

  task automatic test_delay;
    do_instr(3, $urandom, 1'b0, '0, 1'b0, 1);
  endtask

  task automatic test_branch;
    do_instr(int'($urandom_range(0, 2)), $urandom, 1'b1, 32'h0000_0103, 1'b0, 1);
    checks++;
    if (imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL branch_addr got=%h exp=00000100", imem_addr); end
  endtask

  task automatic test_pc_wrap;
    do_instr(0, $urandom, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);
    do_instr(0, $urandom, 1'b0, '0, 1'b0, 1);
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got=%h exp=0", pc); end
  endtask

  task automatic test_halt;
    do_instr(1, $urandom, 1'b0, '0, 1'b1, 5);
    do_instr(0, $urandom, 1'b1, 32'h0000_1234, 1'b1, 3);
    checks++;
    if (imem_addr !== 32'h0000_1234) begin errors++; $display("FAIL halt_branch_addr got=%h exp=00001234", imem_addr); end
  endtask

  task automatic test_cnt_wrap;
    force dut.instr_cnt = 32'hFFFF_FFFE;
    #1 release dut.instr_cnt;
    mcnt = 32'hFFFF_FFFE;
    do_instr(0, $urandom, 1'b0, '0, 1'b0, 1);
    do_instr(0, $urandom, 1'b0, '0, 1'b0, 1);
    checks++;
    if (instr_cnt !== 32'h0) begin errors++; $display("FAIL cnt_wrap got=%h exp=0", instr_cnt); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      do_instr(int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)),
               $urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_reset_mid_f;
    imem_ack = 1'b0;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (phase !== 5'b00001) begin errors++; $display("FAIL midrst_phase got=%b exp=00001", phase); end
    if (pc !== RPC) begin errors++; $display("FAIL midrst_pc got=%h exp=%h", pc, RPC); end
    if (ir !== 32'h0) begin errors++; $display("FAIL midrst_ir got=%h exp=0", ir); end
    if (instr_cnt !== 32'h0) begin errors++; $display("FAIL midrst_cnt got=%h exp=0", instr_cnt); end
    @(negedge clk);
    checks++;
    if (phase !== 5'b00001) begin errors++; $display("FAIL midrst_hold got=%b exp=00001", phase); end
    imem_ack = 1'b0;
    rst      = 1'b0;
    mpc = RPC; mcnt = '0; mir = '0;
    do_instr(0, $urandom, 1'b0, '0, 1'b0, 1);
  endtask

`ifdef IF_TIMEOUT_EN
  task automatic test_timeout;
    do_instr(TO - 1, $urandom, 1'b0, '0, 1'b0, 1);
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_edge_err got=%b exp=0", fetch_err); end
    for (int c = 0; c < TO; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (phase !== 5'b00001) begin errors++; $display("FAIL to_wait_phase got=%b exp=00001", phase); end
      imem_ack = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    end
    @(negedge clk);
    checks += 3;
    if (phase !== 5'b00010) begin errors++; $display("FAIL to_phase got=%b exp=00010", phase); end
    if (ir !== 32'h0) begin errors++; $display("FAIL to_ir got=%h exp=0", ir); end
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", fetch_err); end
    imem_ack = 1'b1; imem_rdata = $urandom;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    mpc = mpc + 32'd4; mcnt = mcnt + 32'd1; mir = '0;
    checks += 3;
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", fetch_err); end
    if (ir !== 32'h0) begin errors++; $display("FAIL to_stray_ir got=%h exp=0", ir); end
    if (pc !== mpc) begin errors++; $display("FAIL to_pc got=%h exp=%h", pc, mpc); end
  endtask
`else
  task automatic test_no_timeout;
    for (int c = 0; c < 2 * TO + 8; c++) begin
      if (c > 0) @(negedge clk);
      checks += 2;
      if (phase !== 5'b00001) begin errors++; $display("FAIL nto_phase got=%b exp=00001", phase); end
      if (fetch_err !== 1'b0) begin errors++; $display("FAIL nto_err got=%b exp=0", fetch_err); end
      imem_ack = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    end
    @(negedge clk);
    do_instr(0, $urandom, 1'b0, '0, 1'b0, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_branch();
    test_pc_wrap();
    test_halt();
    test_cnt_wrap();
    test_random();
    test_reset_mid_f();
`ifdef IF_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
